// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer that owns the PC and runs the IMEM request / IR strobe / decode handshake
//   in : clk, rst_n (async active-low), start, redirect, redirect_pc, mem_ack, dec_ready
//   out: mem_req, mem_addr (= pc_q), ir_wr, ir_rd, dec_valid, pc_q, pc_en, fetch_err, busy
module fetch_ctrl #(
  parameter int INST_W   = 67,
  parameter int ADDR_W   = 32,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              ir_wr,
  output logic              ir_rd,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] pc_q,
  output logic              pc_en,
  output logic              fetch_err,
  output logic              busy
);
  if (INST_W < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("fetch_ctrl: INST_W and TIMEOUT must be >= 1");
  end
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, LOAD, VALID, ERR} state_e;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? REQ : IDLE;
      REQ:     state_d = mem_ack ? LOAD : (cnt_q == CW'(TIMEOUT - 1) ? ERR : REQ);
      LOAD:    state_d = VALID;
      VALID:   state_d = dec_ready ? (start ? REQ : IDLE) : VALID;
      default: state_d = ERR;
    endcase
    if (redirect) state_d = start ? REQ : IDLE;
    cnt_d = (state_q == REQ && !redirect) ? cnt_q + 1'b1 : '0;
    pc_d  = redirect ? redirect_pc : (state_q == LOAD ? pc_q + ADDR_W'(PC_STEP) : pc_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end
  assign mem_req   = state_q == REQ;
  assign mem_addr  = pc_q;
  assign ir_wr     = state_q == LOAD;
  // a redirect during LOAD replaces the increment, so the advance pulse is withheld
  assign pc_en     = state_q == LOAD && !redirect;
  assign ir_rd     = state_q == VALID;
  assign dec_valid = state_q == VALID;
  assign fetch_err = state_q == ERR;
  assign busy      = state_q inside {REQ, LOAD, VALID};
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed + randomized check of fetch_ctrl against a behavioural fetch model
module tb_fetch_ctrl;
  localparam int TIMEOUT = 15;
  localparam int P_IDLE = 0, P_REQ = 1, P_LOAD = 2, P_VALID = 3, P_ERR = 4;
  logic        clk = 0, rst_n = 0, start = 0, redirect = 0, mem_ack = 0, dec_ready = 0;
  logic [31:0] redirect_pc = 0;
  logic        mem_req, ir_wr, ir_rd, dec_valid, pc_en, fetch_err, busy;
  logic [31:0] mem_addr, pc_q;
  int          n_chk = 0, n_fail = 0;
  int          m_ph = P_IDLE, m_wait = 0;
  logic [31:0] m_pc = 0;
  fetch_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .ir_wr(ir_wr), .ir_rd(ir_rd),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .pc_q(pc_q), .pc_en(pc_en),
    .fetch_err(fetch_err), .busy(busy)
  );
  always #5 clk = ~clk;
  wire [6:0] dvec = {mem_req, ir_wr, ir_rd, dec_valid, pc_en, fetch_err, busy};
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [6:0] exp_vec();
    logic rq = m_ph == P_REQ, ld = m_ph == P_LOAD, vl = m_ph == P_VALID;
    return {rq, ld, vl, vl, ld && !redirect, m_ph == P_ERR, rq || ld || vl};
  endfunction
  task automatic model_reset();
    m_ph = P_IDLE; m_wait = 0; m_pc = 0;
  endtask
  task automatic model_step();
    if (redirect) begin
      m_pc = redirect_pc; m_wait = 0; m_ph = start ? P_REQ : P_IDLE;
    end else if (m_ph == P_IDLE) begin
      if (start) begin m_ph = P_REQ; m_wait = 0; end
    end else if (m_ph == P_REQ) begin
      m_wait++;
      if (mem_ack) m_ph = P_LOAD;
      else if (m_wait >= TIMEOUT) m_ph = P_ERR;
    end else if (m_ph == P_LOAD) begin
      m_pc = m_pc + 32'd4; m_ph = P_VALID;
    end else if (m_ph == P_VALID && dec_ready) begin
      m_ph = start ? P_REQ : P_IDLE; m_wait = 0;
    end
  endtask
  task automatic cyc(input logic s, input logic rd, input logic [31:0] rpc, input logic ack,
                     input logic rdy, input string tag);
    start = s; redirect = rd; redirect_pc = rpc; mem_ack = ack; dec_ready = rdy;
    #1;
    check({tag, " out"}, 64'(dvec), 64'(exp_vec()));
    check({tag, " pc"}, 64'(pc_q), 64'(m_pc));
    check({tag, " addr"}, 64'(mem_addr), 64'(m_pc));
    model_step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset out", 64'(dvec), 64'(0));
    check("reset pc", 64'(pc_q), 64'(0));
    rst_n = 1;
    cyc(1, 0, 0, 0, 1, "lat idle");
    cyc(1, 0, 0, 1, 1, "lat req");
    cyc(1, 0, 0, 0, 1, "lat load");
    check("lat pc4", 64'(pc_q), 64'h4);
    cyc(1, 0, 0, 0, 1, "lat valid");
    cyc(1, 0, 0, 0, 1, "lat req2");
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, "slow ack");
    cyc(1, 0, 0, 1, 0, "slow ack5");
    cyc(1, 0, 0, 0, 0, "slow load");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, "stall");
    cyc(1, 0, 0, 0, 1, "stall end");
    for (int i = 0; i < TIMEOUT + 3; i++) cyc(1, 0, 0, 0, 0, "timeout");
    check("timeout err", 64'(fetch_err), 64'(1));
    check("timeout busy", 64'(busy), 64'(0));
    cyc(1, 1, 32'h100, 0, 0, "err redir");
    cyc(1, 1, 32'h200, 1, 1, "redir ack");
    cyc(1, 0, 0, 1, 1, "redir req");
    cyc(1, 1, 32'h200, 0, 1, "redir load");
    check("redir load pc", 64'(pc_q), 64'h200);
    cyc(1, 1, 32'hFFFF_FFFC, 0, 1, "wrap redir");
    cyc(0, 0, 0, 1, 1, "wrap req");
    cyc(0, 0, 0, 0, 1, "wrap load");
    check("wrap pc", 64'(pc_q), 64'h0);
    cyc(0, 0, 0, 0, 1, "wrap valid");
    cyc(0, 0, 0, 0, 1, "wrap idle");
    cyc(1, 1, 32'h3C, 0, 0, "ar redir");
    cyc(1, 0, 0, 1, 0, "ar req");
    cyc(1, 0, 0, 0, 0, "ar load");
    cyc(1, 0, 0, 0, 0, "ar valid");
    check("ar pre pc", 64'(pc_q), 64'h40);
    #2 rst_n = 0;
    #1;
    check("async out", 64'(dvec), 64'(0));
    check("async pc", 64'(pc_q), 64'(0));
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    for (int blk = 0; blk < 30; blk++) begin
      int ack_p = (blk % 3 == 0) ? 0 : (blk % 3 == 1) ? 15 : 70;
      int rdy_p = $urandom_range(20, 90);
      for (int i = 0; i < 100; i++) begin
        logic [31:0] rpc;
        int sel = $urandom_range(3);
        rpc = sel == 0 ? 32'h100 : sel == 1 ? 32'h200 : sel == 2 ? 32'hFFFF_FFFC : ($urandom & ~32'h3);
        cyc($urandom_range(99) < 85, $urandom_range(99) < 3, rpc,
            $urandom_range(99) < ack_p, $urandom_range(99) < rdy_p, "rand");
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
